// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai21_bist.sv
//------------------------------------------------------------------------------
// Module   : gf180mcu_fd_sc_mcu9t5v0__oai21_bist
// Purpose  : Gray-order self-test sequencer for one OAI21 cell (ZN = !((A1|A2)&B))
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gf180mcu_fd_sc_mcu9t5v0__oai21_bist #(
    parameter int PASSES     = 4,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             ZN_OBS,
    output logic             A1,
    output logic             A2,
    output logic             B,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic             FAIL_VLD,
    output logic [2:0]       FAIL_VEC
);

    localparam int PASS_W = $clog2(PASSES + 1);
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        vec_idx;
    logic [PASS_W-1:0] pass_cnt;
    logic [SET_W-1:0]  settle_cnt;
    logic              start_run;
    logic              do_sample;
    logic              last_vec;
    logic              mismatch;
    logic [2:0]        cur_vec;

    // Binary-reflected Gray code gives the single-toggle vector order.
    function automatic logic [2:0] gray_of(input logic [2:0] idx);
        return idx ^ (idx >> 1);
    endfunction

    function automatic logic oai21(input logic [2:0] v);
        return ~((v[2] | v[1]) & v[0]);
    endfunction

    assign cur_vec  = {A1, A2, B};
    assign mismatch = (ZN_OBS != oai21(cur_vec));

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        do_sample = 1'b0;
        last_vec  = (vec_idx == 3'd7) && (pass_cnt == PASS_W'(PASSES - 1));
        case (state)
            IDLE, FINISH: begin
                if (START) begin
                    state_nxt = SETTLE;
                    start_run = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                do_sample = 1'b1;
                state_nxt = last_vec ? FINISH : SETTLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            vec_idx    <= 3'd0;
            pass_cnt   <= '0;
            settle_cnt <= '0;
            A1         <= 1'b0;
            A2         <= 1'b0;
            B          <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            FAIL_VLD   <= 1'b0;
            FAIL_VEC   <= 3'b000;
        end else begin
            if (start_run) begin
                vec_idx      <= 3'd0;
                pass_cnt     <= '0;
                settle_cnt   <= '0;
                {A1, A2, B}  <= 3'b000;
                BUSY         <= 1'b1;
                DONE         <= 1'b0;
                PASS         <= 1'b0;
                ERR_CNT      <= '0;
                FAIL_VLD     <= 1'b0;
                FAIL_VEC     <= 3'b000;
            end
            if (state == SETTLE) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end
            if (do_sample) begin
                if (mismatch) begin
                    if (ERR_CNT != {CNT_W{1'b1}}) begin
                        ERR_CNT <= ERR_CNT + CNT_W'(1);
                    end
                    if (!FAIL_VLD) begin
                        FAIL_VLD <= 1'b1;
                        FAIL_VEC <= cur_vec;
                    end
                end
                vec_idx    <= vec_idx + 3'd1;
                settle_cnt <= '0;
                if (vec_idx == 3'd7) begin
                    pass_cnt <= pass_cnt + PASS_W'(1);
                end
                if (last_vec) begin
                    {A1, A2, B} <= 3'b000;
                    BUSY        <= 1'b0;
                    DONE        <= 1'b1;
                    // PASS must reflect the mismatch being recorded on this same edge.
                    PASS        <= (ERR_CNT == '0) && !mismatch;
                end else begin
                    {A1, A2, B} <= gray_of(vec_idx + 3'd1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__oai21_bist.sv
//------------------------------------------------------------------------------
// Module   : tb_gf180mcu_fd_sc_mcu9t5v0__oai21_bist
// Purpose  : Self-checking bench for the OAI21 BIST sequencer
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_gf180mcu_fd_sc_mcu9t5v0__oai21_bist;

    localparam int P   = 2;
    localparam int S   = 1;
    localparam int CW  = 8;
    localparam int N   = 8 * P * (S + 1);
    localparam int P2  = 4;
    localparam int S2  = 2;
    localparam int CW2 = 3;
    localparam int N2  = 8 * P2 * (S2 + 1);

    logic clk = 1'b0;
    logic rn = 1'b0;
    logic start = 1'b0;
    logic zn = 1'b0;
    logic start2 = 1'b0;
    logic zn2 = 1'b0;

    logic a1, a2, b, busy, done, pass, fvld;
    logic [CW-1:0] err;
    logic [2:0] fvec;
    logic a1_2, a2_2, b_2, busy2, done2, pass2, fvld2;
    logic [CW2-1:0] err2;
    logic [2:0] fvec2;

    int checks = 0;
    int errors = 0;

    logic [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                 3'b110, 3'b111, 3'b101, 3'b100};
    logic       exp_tab  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu9t5v0__oai21_bist #(.PASSES(P), .SETTLE_CYC(S), .CNT_W(CW)) dut (
        .CLK(clk), .RN(rn), .START(start), .ZN_OBS(zn),
        .A1(a1), .A2(a2), .B(b), .BUSY(busy), .DONE(done), .PASS(pass),
        .ERR_CNT(err), .FAIL_VLD(fvld), .FAIL_VEC(fvec)
    );

    gf180mcu_fd_sc_mcu9t5v0__oai21_bist #(.PASSES(P2), .SETTLE_CYC(S2), .CNT_W(CW2)) dut2 (
        .CLK(clk), .RN(rn), .START(start2), .ZN_OBS(zn2),
        .A1(a1_2), .A2(a2_2), .B(b_2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
        .ERR_CNT(err2), .FAIL_VLD(fvld2), .FAIL_VEC(fvec2)
    );

    // Model results of the most recent run, for scenario-level checks.
    int         last_err;
    bit         last_fvld;
    logic [2:0] last_fvec;

    // mode: 0 ideal cell, 1 stuck-at-1, 2 stuck-at-0, 3 random ZN
    task automatic do_run(input int mode, input bit hold, input string tag);
        int         m_err  = 0;
        bit         m_fvld = 1'b0;
        logic [2:0] m_fvec = 3'b000;
        logic       z;
        logic [2:0] ev;
        int         k;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        checks++;
        if ({busy, done, a1, a2, b} !== {1'b1, 1'b0, gray_tab[0]}) begin
            errors++;
            $display("FAIL %s edge0 busy/done/vec: got %b required %b", tag,
                     {busy, done, a1, a2, b}, {1'b1, 1'b0, gray_tab[0]});
        end
        checks++;
        if ({pass, fvld, fvec} !== 5'b0 || err !== '0) begin
            errors++;
            $display("FAIL %s edge0 cleared results: pass/fvld/fvec=%b err=%0d required all 0",
                     tag, {pass, fvld, fvec}, err);
        end
        for (int t = 1; t <= N; t++) begin
            case (mode)
                0:       z = ~((a1 | a2) & b);
                1:       z = 1'b1;
                2:       z = 1'b0;
                default: z = 1'($urandom_range(0, 1));
            endcase
            zn = z;
            if (t % (S + 1) == 0) begin
                k = (t / (S + 1) - 1) % 8;
                if (z !== exp_tab[k]) begin
                    if (m_err < (2 ** CW) - 1) m_err++;
                    if (!m_fvld) begin
                        m_fvld = 1'b1;
                        m_fvec = gray_tab[k];
                    end
                end
            end
            @(negedge clk);
            ev = (t < N) ? gray_tab[(t / (S + 1)) % 8] : 3'b000;
            checks++;
            if ({busy, done, a1, a2, b} !== {(t < N), (t == N), ev}) begin
                errors++;
                $display("FAIL %s edge%0d busy/done/vec: got %b required %b", tag, t,
                         {busy, done, a1, a2, b}, {(t < N), (t == N), ev});
            end
            checks++;
            if (err !== CW'(m_err) || fvld !== m_fvld || fvec !== m_fvec) begin
                errors++;
                $display("FAIL %s edge%0d results: err=%0d fvld=%b fvec=%b required err=%0d fvld=%b fvec=%b",
                         tag, t, err, fvld, fvec, m_err, m_fvld, m_fvec);
            end
        end
        checks++;
        if (pass !== (m_err == 0)) begin
            errors++;
            $display("FAIL %s pass flag: got %b required %b", tag, pass, (m_err == 0));
        end
        start     = 1'b0;
        last_err  = m_err;
        last_fvld = m_fvld;
        last_fvec = m_fvec;
    endtask

    task automatic test_reset();
        rn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({a1, a2, b, busy, done, pass, fvld, fvec} !== 10'b0 || err !== '0) begin
            errors++;
            $display("FAIL reset_state: outs=%b err=%0d required all 0",
                     {a1, a2, b, busy, done, pass, fvld, fvec}, err);
        end
        rn = 1'b1;
    endtask

    task automatic test_ideal();
        do_run(0, 1'b0, "ideal");
        checks++;
        if (err !== '0 || pass !== 1'b1 || fvld !== 1'b0) begin
            errors++;
            $display("FAIL ideal_summary: err=%0d pass=%b fvld=%b required 0/1/0", err, pass, fvld);
        end
    endtask

    task automatic test_stuck1();
        do_run(1, 1'b0, "stuck1");
        checks++;
        if (err !== CW'(6) || fvld !== 1'b1 || fvec !== 3'b011 || pass !== 1'b0) begin
            errors++;
            $display("FAIL stuck1_summary: err=%0d fvld=%b fvec=%b pass=%b required 6/1/011/0",
                     err, fvld, fvec, pass);
        end
    endtask

    task automatic test_stuck0_then_restart();
        do_run(2, 1'b0, "stuck0");
        checks++;
        if (err !== CW'(10) || fvec !== 3'b000 || fvld !== 1'b1) begin
            errors++;
            $display("FAIL stuck0_summary: err=%0d fvec=%b fvld=%b required 10/000/1", err, fvec, fvld);
        end
        do_run(0, 1'b0, "restart_from_finish");
        checks++;
        if (err !== '0 || pass !== 1'b1) begin
            errors++;
            $display("FAIL restart_summary: err=%0d pass=%b required 0/1", err, pass);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            do_run(3, 1'b0, "random");
        end
    endtask

    task automatic test_start_held();
        do_run(3, 1'b1, "start_held");
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start = 1'b1;
        zn    = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= 9; t++) @(negedge clk);
        checks++;
        if (err !== CW'(3)) begin
            errors++;
            $display("FAIL midrun_pre_reset_err: got %0d required 3", err);
        end
        rn = 1'b0;
        #1;
        checks++;
        if ({a1, a2, b, busy, done, pass, fvld, fvec} !== 10'b0 || err !== '0) begin
            errors++;
            $display("FAIL midrun_async_reset: outs=%b err=%0d required all 0",
                     {a1, a2, b, busy, done, pass, fvld, fvec}, err);
        end
        @(negedge clk);
        rn = 1'b1;
        do_run(0, 1'b0, "after_reset");
    endtask

    task automatic test_saturation();
        int expc;
        expc = 5 * P2;
        if (expc > (2 ** CW2) - 1) expc = (2 ** CW2) - 1;
        zn2 = 1'b0;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int t = 1; t < N2; t++) @(negedge clk);
        checks++;
        if (done2 !== 1'b0 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL sat_pre_done: done=%b busy=%b required 0/1", done2, busy2);
        end
        @(negedge clk);
        checks++;
        if (done2 !== 1'b1 || busy2 !== 1'b0 || err2 !== CW2'(expc) || pass2 !== 1'b0
            || fvld2 !== 1'b1 || fvec2 !== 3'b000) begin
            errors++;
            $display("FAIL saturation: done=%b busy=%b err=%0d pass=%b fvld=%b fvec=%b required 1/0/%0d/0/1/000",
                     done2, busy2, err2, pass2, fvld2, fvec2, expc);
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck1();
        test_stuck0_then_restart();
        test_random();
        test_start_held();
        test_reset_mid_run();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gf180mcu_fd_sc_mcu9t5v0__oai21_bist.md
# gf180mcu_fd_sc_mcu9t5v0__oai21_bist

Self-test sequencer that drives the A1, A2 and B inputs of one OAI21 cell instance and captures its ZN output. It walks all 8 input vectors in Gray order, checks each captured ZN against ZN = !((A1 | A2) & B), and repeats the sweep a set number of times. It counts mismatches and reports the first failing vector. It sits directly upstream and downstream of the OAI21 cell under test in the library's silicon test structures.

## Interface
- PASSES, default 4: number of full 8-vector sweeps per run; must be ≥1.
- SETTLE_CYC, default 1: cycles each vector is held before the sample cycle; must be ≥1.
- CNT_W, default 8: width of the mismatch counter.

- CLK  input  1  rising-edge clock.
- RN  input  1  reset; asynchronous assert, active-low.
- START  input  1  run request; sampled on CLK in IDLE or FINISH only.
- ZN_OBS  input  1  observed ZN of the cell under test.
- A1, A2, B  output  1 each  registered drives to the cell under test.
- BUSY  output  1  high while a run is in progress.
- DONE  output  1  high in FINISH.
- PASS  output  1  DONE & (ERR_CNT == 0).
- ERR_CNT  output  CNT_W  mismatch count; saturating.
- FAIL_VLD  output  1  at least one mismatch recorded this run.
- FAIL_VEC  output  3  {A1,A2,B} of the first mismatch.

## Operation
- Vector order, as {A1,A2,B}: 000, 001, 011, 010, 110, 111, 101, 100. Exactly one input toggles per step.
- Expected ZN per vector, in that order: 1, 1, 0, 1, 1, 0, 0, 1.
- FSM states: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE, START=1: clear ERR_CNT, FAIL_VLD and FAIL_VEC. Drive vector 0, set settle counter to 0, go to SETTLE.
- SETTLE: increment the settle counter each edge. At the edge where counter == SETTLE_CYC-1, go to SAMPLE.
- SAMPLE edge:
  - Compare ZN_OBS with the expected value for the current vector.
  - On mismatch, ERR_CNT increments and saturates at 2^CNT_W-1.
  - On the first mismatch of a run, set FAIL_VLD and latch FAIL_VEC.
  - Then advance the vector index (3 bits, wraps 7→0) and, on wrap, the pass counter.
  - If this was vector 7 of pass PASSES-1, drive A1/A2/B = 000 and go to FINISH. Otherwise drive the next vector and go to SETTLE.
- FINISH: DONE=1. All results hold until START or reset. START=1 behaves exactly as from IDLE (clear and restart).
- START is ignored in SETTLE and SAMPLE.
- An asserted RN returns the block to IDLE from any state, mid-run included. No partial results are retained.

## Timing
- Reset values: A1=A2=B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VLD=0, FAIL_VEC=000. The FSM is in IDLE.
- BUSY, DONE, PASS and all outputs are registered. There are no combinational paths from START or ZN_OBS to any output.
- Each vector is driven for SETTLE_CYC+1 cycles. ZN_OBS is sampled at the edge SETTLE_CYC+1 cycles after that vector was applied.
- The START edge is edge 0. BUSY=1 and vector 0 appear after edge 0. DONE=1 and BUSY=0 appear after edge N = 8·PASSES·(SETTLE_CYC+1).
- ERR_CNT and FAIL_* update on the SAMPLE edge that detects the mismatch.
- A START in FINISH: DONE falls and BUSY rises after the same edge.

## Test plan
- Ideal model ZN_OBS = !((A1|A2)&B), PASSES=2, SETTLE_CYC=1, START pulse → required:
  - DONE rises after edge 32.
  - ERR_CNT=0, PASS=1, FAIL_VLD=0.
  - A1/A2/B sequence matches the Gray order, each vector held 2 cycles.
- ZN_OBS stuck at 1, PASSES=2 → ERR_CNT=6, FAIL_VLD=1, FAIL_VEC=011, PASS=0.
- ZN_OBS stuck at 0, PASSES=2 → ERR_CNT=10, FAIL_VEC=000. Then START from FINISH with the ideal model → ERR_CNT=0, PASS=1.
- CNT_W=3, PASSES=4, ZN_OBS stuck at 0 → ERR_CNT saturates at 7 and does not wrap.
- START held high throughout a run → no restart while BUSY; DONE after edge N.
- RN pulsed low mid-run, after the 3rd mismatch, then START → all outputs return to reset values immediately. The new run completes from vector 0 in N cycles.
